// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if
// Bundles the request and response signals between the instruction decoder
// (master) and the HI/LO multiply/divide unit (slave).
//   start        issue a MULT/MULTU/DIV/DIVU
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands (dividend / divisor for divides)
//   mthi, mtlo   write wdata into HI / LO
//   wdata        MTHI/MTLO data
//   busy         operation in flight, decoder must stall HI/LO accesses
//   done         one-cycle pulse when HI/LO first hold a new result
//   div_by_zero  last divide had a zero divisor
//   hi, lo       architectural HI/LO registers
interface hilo_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, mthi, mtlo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// Multiplies use shift-add, divides use restoring shift-subtract, both on
// magnitudes; signs are applied in a final fix-up cycle.
//   clk_i   rising-edge clock
//   rst_ni  asynchronous reset, active low
//   bus_io  slave side of hilo_muldiv_if (request, HI/LO, status)
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic           clk_i,
   input logic           rst_ni,
   hilo_muldiv_if.slave  bus_io
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t             state_q;
   logic [CW-1:0]      count_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opB_q;
   logic [WIDTH-1:0]   rawA_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               isDiv_q;
   logic               negResult_q;
   logic               negRem_q;
   logic               divZero_q;
   logic               busy_q;
   logic               done_q;

   logic               isSigned;
   logic               isDivIn;
   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prodFinal;
   logic [WIDTH-1:0]   quotFinal;
   logic [WIDTH-1:0]   remFinal;

   // Operand conditioning at issue: signed ops work on magnitudes.
   always_comb begin
      isSigned = ~bus_io.op[0];
      isDivIn  = bus_io.op[1];
      absA     = (isSigned && bus_io.a[WIDTH-1]) ? -bus_io.a : bus_io.a;
      absB     = (isSigned && bus_io.b[WIDTH-1]) ? -bus_io.b : bus_io.b;
   end

   // One radix-2 step. For multiply the accumulator holds {partial, multiplier};
   // for divide it holds {remainder, dividend/quotient}, the quotient bits
   // shifting in from the bottom as dividend bits leave the top.
   always_comb begin
      mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
      divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      divDiff  = divShift - {1'b0, opB_q};
      if (isDiv_q) begin
         if (divShift >= {1'b0, opB_q}) begin
            acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_d = {mulSum, acc_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up. A zero divisor leaves quotient all-ones naturally, but HI must
   // return the dividend exactly as supplied, not its magnitude.
   always_comb begin
      prodFinal = negResult_q ? -acc_q : acc_q;
      quotFinal = negResult_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      remFinal  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (divZero_q) begin
         quotFinal = '1;
         remFinal  = rawA_q;
      end
   end

   // Control FSM with registered status outputs. In IDLE, start wins over
   // MTHI/MTLO; while busy every request is ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         opB_q       <= '0;
         rawA_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         isDiv_q     <= 1'b0;
         negResult_q <= 1'b0;
         negRem_q    <= 1'b0;
         divZero_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_io.start) begin
                  state_q     <= ITER;
                  busy_q      <= 1'b1;
                  count_q     <= '0;
                  acc_q       <= {{WIDTH{1'b0}}, absA};
                  opB_q       <= absB;
                  rawA_q      <= bus_io.a;
                  isDiv_q     <= isDivIn;
                  negResult_q <= isSigned && (bus_io.a[WIDTH-1] != bus_io.b[WIDTH-1]);
                  negRem_q    <= isSigned && isDivIn && bus_io.a[WIDTH-1];
                  divZero_q   <= isDivIn && (bus_io.b == '0);
               end else begin
                  if (bus_io.mthi) hi_q <= bus_io.wdata;
                  if (bus_io.mtlo) lo_q <= bus_io.wdata;
               end
            end
            ITER: begin
               acc_q   <= acc_d;
               count_q <= count_q + CW'(1);
               if (count_q == CW'(WIDTH-1)) state_q <= FIX;
            end
            FIX: begin
               if (isDiv_q) begin
                  hi_q <= remFinal;
                  lo_q <= quotFinal;
               end else begin
                  hi_q <= prodFinal[2*WIDTH-1:WIDTH];
                  lo_q <= prodFinal[WIDTH-1:0];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.busy        = busy_q;
   assign bus_io.done        = done_q;
   assign bus_io.div_by_zero = divZero_q;
   assign bus_io.hi          = hi_q;
   assign bus_io.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// Scoreboard bench for hilo_muldiv_unit: every issued operation pushes its
// expected {div_by_zero, hi, lo} from an arithmetic reference model; a monitor
// pops and compares whenever done is seen.
module tb_hilo_muldiv_unit;
   logic clk;
   logic rstN;
   int   total;
   int   bad;
   logic [64:0] expQ[$];
   logic [31:0] modelHi;
   logic [31:0] modelLo;

   hilo_muldiv_if #(.WIDTH(32)) bus ();

   hilo_muldiv_unit #(.WIDTH(32)) dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus_io (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain 64-bit arithmetic; SV signed / and % truncate toward zero
   function automatic logic [64:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa;
      longint sb;
      longint r;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin r = sa * sb; return {1'b0, r[63:0]}; end
         2'b01: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
         2'b10: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            r = sa / sb;
            u[31:0] = r[31:0];
            r = sa % sb;
            u[63:32] = r[31:0];
            return {1'b0, u};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pickVal();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Compare and count
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one operation at a negedge and record its expected result
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic withMt);
      logic [64:0] e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.mthi  = withMt;
      bus.mtlo  = withMt;
      bus.wdata = 32'h0000_0055;
      e = refModel(op, a, b);
      expQ.push_back(e);
      modelHi = e[63:32];
      modelLo = e[31:0];
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
   endtask

   // Count negedges with busy high; an expired bound counts as a failure
   task automatic waitIdle(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) return;
         cycles++;
      end
      checkOutput("busy timeout", 64'd1, 64'd0);
   endtask

   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      applyStimulus(op, a, b, 1'b0);
      waitIdle(cyc);
      checkOutput("busy length", 64'(cyc), 64'd33);
   endtask

   task automatic mtWrite(input logic wHi, input logic wLo, input logic [31:0] d);
      @(negedge clk);
      bus.mthi  = wHi;
      bus.mtlo  = wLo;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      if (wHi) modelHi = d;
      if (wLo) modelLo = d;
      checkOutput("mt hi", 64'(bus.hi), 64'(modelHi));
      checkOutput("mt lo", 64'(bus.lo), 64'(modelLo));
      checkOutput("mt no done", 64'(bus.done), 64'd0);
   endtask

   // Monitor: every done pops one expectation
   always @(negedge clk) begin
      logic [64:0] e;
      if (rstN && bus.done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected done", 64'd1, 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("result hi", 64'(bus.hi), 64'(e[63:32]));
            checkOutput("result lo", 64'(bus.lo), 64'(e[31:0]));
            checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(e[64]));
            checkOutput("busy at done", 64'(bus.busy), 64'd0);
         end
      end
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cyc;
      logic [1:0] rop;
      total = 0;
      bad   = 0;
      rstN  = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
      modelHi = '0; modelLo = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      checkOutput("reset dbz", 64'(bus.div_by_zero), 64'd0);
      checkOutput("reset hi", 64'(bus.hi), 64'd0);
      checkOutput("reset lo", 64'(bus.lo), 64'd0);
      rstN = 1'b1;

      // Directed cases
      runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(2'b00, 32'hFFFF_FFFD, 32'd7);
      runOp(2'b10, 32'hFFFF_FFF9, 32'd2);
      runOp(2'b11, 32'd100, 32'd7);
      runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp(2'b10, 32'd5, 32'd0);
      runOp(2'b01, 32'd2, 32'd3);

      // Requests while busy are ignored
      applyStimulus(2'b01, 32'd2, 32'd3, 1'b0);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
      bus.mthi = 1'b1; bus.wdata = 32'h0000_DEAD;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.mthi = 1'b0;
      waitIdle(cyc);
      #1;
      checkOutput("busy-ignored hi", 64'(bus.hi), 64'd0);
      checkOutput("busy-ignored lo", 64'(bus.lo), 64'd6);
      mtWrite(1'b1, 1'b1, 32'h0000_1234);

      // start has priority over mthi/mtlo in the same cycle
      applyStimulus(2'b01, 32'd1, 32'd1, 1'b1);
      waitIdle(cyc);

      // Randomized operations interleaved with MTHI/MTLO
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         runOp(rop, pickVal(), pickVal());
         if ($urandom_range(0, 3) == 0) mtWrite(1'($urandom), 1'($urandom), $urandom);
      end
      runOp(2'b01, 32'hABCD_0123, 32'h0000_0F0F);

      // Reset mid-operation abandons it
      applyStimulus(2'b11, 32'd9, 32'd3, 1'b0);
      repeat (10) @(negedge clk);
      rstN = 1'b0;
      #1;
      expQ.delete();
      checkOutput("midreset busy", 64'(bus.busy), 64'd0);
      checkOutput("midreset hi", 64'(bus.hi), 64'd0);
      checkOutput("midreset lo", 64'(bus.lo), 64'd0);
      checkOutput("midreset done", 64'(bus.done), 64'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      runOp(2'b11, 32'd9, 32'd3);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
